// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control unit driving the multi-cycle datapath.
// It fetches over a variable-latency instruction memory handshake, decodes,
// executes and writes back. It supports jal/jr, a sticky halt and a
// retired-instruction counter.
// Optional feature: define MC_MEM_TIMEOUT_EN to abort a memory wait that
// lasts MEM_TIMEOUT cycles. The abort pulses mem_err and restarts at IF.
module mc_ctrl_fsm #(
    parameter int OPC_W       = 6,
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   decode,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               RegWre,
    output logic               PCWre,
    output logic               IRWre,
    output logic               ALUSrcB,
    output logic               ALUM2Reg,
    output logic               DataMemRw,
    output logic               ExtSel,
    output logic               InsMemRW,
    output logic               WrRegData,
    output logic [1:0]         PCSrc,
    output logic [1:0]         RegOut,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic [2:0]         next_state,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic               halted,
    output logic               mem_err
);

    typedef enum logic [2:0] {
        S_IF      = 3'b000,
        S_ID      = 3'b001,
        S_EXE_MEM = 3'b010,
        S_MEM     = 3'b011,
        S_WB_LD   = 3'b100,
        S_EXE_BR  = 3'b101,
        S_EXE     = 3'b110,
        S_WB      = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    // The opcode values are 6 bits wide. They are zero-extended to the decode width.
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6'b000001);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6'b010000);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(6'b010001);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'b010010);
    localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(6'b100110);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b110001);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b110100);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b111000);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(6'b111001);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(6'b111010);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(6'b111111);

    // These configurations are nonsensical. They are rejected at elaboration.
    if (ALUOP_W < 3) begin : g_bad_aluop_w
        $error("mc_ctrl_fsm: ALUOP_W must be at least 3");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
        $error("mc_ctrl_fsm: MEM_TIMEOUT must be at least 1");
    end

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    timeout;
    logic    op_r_type, op_i_type, op_mem, op_halt;

    assign op_r_type = (decode == OP_ADD) || (decode == OP_SUB) || (decode == OP_OR) ||
                       (decode == OP_AND) || (decode == OP_SLT);
    assign op_i_type = (decode == OP_ADDI) || (decode == OP_ORI);
    assign op_mem    = (decode == OP_LW) || (decode == OP_SW);
    assign op_halt   = (decode == OP_HALT);

    assign state      = state_q;
    assign next_state = state_d;
    assign ALUOp      = ALUOP_W'(alu_op);

    // State register, sticky halt flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (reset) begin
            state_q    <= S_IF;
            retire_cnt <= '0;
            halted     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (PCWre) retire_cnt <= retire_cnt + CNT_W'(1);
            if (state_q == S_ID && op_halt) halted <= 1'b1;
        end
    end

`ifdef MC_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;

    assign waiting = (state_q == S_IF && !imem_ready) || (state_q == S_MEM && !dmem_ready);
    assign timeout = waiting && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // Count memory wait cycles. Any state change clears the count, including entry to IF or MEM.
    always_ff @(posedge clk) begin
        if (reset || timeout || state_d != state_q) wait_cnt <= '0;
        else if (waiting) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and strobe decode from state, opcode, zero and the ready inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        RegWre    = 1'b0;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcB   = 1'b0;
        ALUM2Reg  = 1'b0;
        DataMemRw = 1'b0;
        ExtSel    = 1'b0;
        InsMemRW  = 1'b1;
        WrRegData = 1'b0;
        PCSrc     = 2'b00;
        RegOut    = 2'b00;
        alu_op    = ALU_ADD;
        mem_err   = 1'b0;

        case (state_q)
            S_IF: begin
                if (imem_ready) begin
                    IRWre   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (halted || op_halt) begin
                    state_d = S_ID;   // parked until reset
                end else if (op_r_type || op_i_type) begin
                    state_d = S_EXE;
                end else if (op_mem) begin
                    state_d = S_EXE_MEM;
                end else if (decode == OP_BEQ) begin
                    state_d = S_EXE_BR;
                end else begin
                    // The jumps and the unknown-opcode NOP all retire here.
                    PCWre   = 1'b1;
                    state_d = S_IF;
                    if (decode == OP_J) begin
                        PCSrc = 2'b11;
                    end else if (decode == OP_JR) begin
                        PCSrc = 2'b10;
                    end else if (decode == OP_JAL) begin
                        PCSrc  = 2'b11;
                        RegWre = 1'b1;   // $31 <- PC+4
                    end
                end
            end
            S_EXE: begin
                if (decode == OP_SUB)                          alu_op = ALU_SUB;
                else if (decode == OP_AND)                     alu_op = ALU_AND;
                else if (decode == OP_OR || decode == OP_ORI)  alu_op = ALU_OR;
                else if (decode == OP_SLT)                     alu_op = ALU_SLT;
                else                                           alu_op = ALU_ADD;
                ALUSrcB = op_i_type;
                ExtSel  = (decode == OP_ADDI);   // ori zero-extends
                state_d = S_WB;
            end
            S_WB: begin
                RegWre    = 1'b1;
                WrRegData = 1'b1;
                PCWre     = 1'b1;
                RegOut    = op_r_type ? 2'b10 : 2'b01;
                state_d   = S_IF;
            end
            S_EXE_BR: begin
                alu_op  = ALU_SUB;
                ExtSel  = 1'b1;
                PCWre   = 1'b1;
                PCSrc   = zero ? 2'b01 : 2'b00;
                state_d = S_IF;
            end
            S_EXE_MEM: begin
                alu_op  = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                DataMemRw = (decode == OP_SW);
                if (dmem_ready) begin
                    if (decode == OP_SW) begin
                        PCWre   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB_LD;
                    end
                end
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                ALUM2Reg  = 1'b1;
                WrRegData = 1'b1;
                RegOut    = 2'b01;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // A watchdog abort suppresses every write and restarts the fetch.
        if (timeout) begin
            mem_err   = 1'b1;
            state_d   = S_IF;
            RegWre    = 1'b0;
            PCWre     = 1'b0;
            DataMemRw = 1'b0;
        end

        // A reset cycle must not commit anything the interrupted instruction was doing.
        if (reset) begin
            state_d   = S_IF;
            RegWre    = 1'b0;
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            DataMemRw = 1'b0;
            mem_err   = 1'b0;
        end
    end

endmodule
